// File: rtl/cvxif_sbox_instr_pkg.sv
// Shared definitions for the CV-X-IF S-box unit.
// Holds the result-buffer depth and the default result-beat layout.
package cvxif_sbox_instr_pkg;

  localparam int unsigned SBOX_RESBUF_DEPTH = 4;
  localparam int unsigned SBOX_RD_W         = 5;
  localparam int unsigned SBOX_XLEN         = 64;
  localparam int unsigned SBOX_HARTID_W     = 64;
  localparam int unsigned SBOX_ID_W         = 3;

  // Default-width beat. Modules that take the field types as parameters
  // build an identically ordered struct locally, since packages cannot be parameterised.
  typedef struct packed {
    logic [SBOX_XLEN-1:0]     result;
    logic [SBOX_HARTID_W-1:0] hartid;
    logic [SBOX_ID_W-1:0]     id;
    logic [SBOX_RD_W-1:0]     rd;
    logic                     we;
  } sbox_result_t;

endpackage

// File: rtl/cvxif_sbox_result_buffer.sv
// Result FIFO between the S-box unit and the CV-X-IF result channel.
// Returns issue credit so no issued instruction can find the buffer full.
module cvxif_sbox_result_buffer
  import cvxif_sbox_instr_pkg::*;
#(
  parameter int unsigned Depth    = SBOX_RESBUF_DEPTH,
  parameter int unsigned XLEN     = 64,
  parameter type         hartid_t = logic [63:0],
  parameter type         id_t     = logic [2:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_fire_i,
  output logic                     issue_ready_o,
  input  logic                     in_valid_i,
  input  logic [XLEN-1:0]          in_result_i,
  input  hartid_t                  in_hartid_i,
  input  id_t                      in_id_i,
  input  logic [SBOX_RD_W-1:0]     in_rd_i,
  input  logic                     in_we_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output hartid_t                  hartid_o,
  output id_t                      id_o,
  output logic [SBOX_RD_W-1:0]     rd_o,
  output logic                     we_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [XLEN-1:0]      result;
    hartid_t              hartid;
    id_t                  id;
    logic [SBOX_RD_W-1:0] rd;
    logic                 we;
  } entry_t;

  entry_t mem [Depth];

  logic [PtrW-1:0] wptr_reg, rptr_reg;
  logic [CntW-1:0] count_reg;
  logic            pending_reg;
  logic            overflow_reg;

  logic   push, pop, full, accept, drop;
  entry_t in_entry, head;

  assign full   = (count_reg == CntW'(Depth));
  assign push   = in_valid_i & ~flush_i;
  assign pop    = result_valid_o & result_ready_i & ~flush_i;
  // A full buffer still takes a beat when the head leaves in the same cycle.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign in_entry = '{result: in_result_i, hartid: in_hartid_i, id: in_id_i,
                      rd: in_rd_i, we: in_we_i};

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wptr_reg] <= in_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (flush_i) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (accept) wptr_reg <= wptr_reg + 1'b1;
      if (pop)    rptr_reg <= rptr_reg + 1'b1;
      count_reg   <= count_reg + CntW'(accept) - CntW'(pop);
      pending_reg <= issue_fire_i;
      if (drop)   overflow_reg <= 1'b1;
    end
  end

  // Stale storage is masked so an empty buffer presents all-zero fields.
  assign head = (count_reg != '0) ? mem[rptr_reg] : '0;

  assign result_valid_o = (count_reg != '0);
  assign result_o       = head.result;
  assign hartid_o       = head.hartid;
  assign id_o           = head.id;
  assign rd_o           = head.rd;
  assign we_o           = head.we;
  assign count_o        = count_reg;
  assign overflow_o     = overflow_reg;

  // Credit uses registered state only, so a pop frees credit one cycle later.
  assign issue_ready_o = ({1'b0, count_reg} + (CntW + 1)'(pending_reg)) < (CntW + 1)'(Depth);

endmodule

// File: tb/tb_cvxif_sbox_result_buffer.sv
// Directed self-checking bench for cvxif_sbox_result_buffer.
module tb_cvxif_sbox_result_buffer;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, issue_fire_i, issue_ready_o;
  logic        in_valid_i, in_we_i, result_valid_o, result_ready_i, we_o, overflow_o;
  logic [63:0] in_result_i, in_hartid_i, result_o, hartid_o;
  logic [2:0]  in_id_i, id_o;
  logic [4:0]  in_rd_i, rd_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cvxif_sbox_result_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_fire_i(issue_fire_i), .issue_ready_o(issue_ready_o),
    .in_valid_i(in_valid_i), .in_result_i(in_result_i), .in_hartid_i(in_hartid_i),
    .in_id_i(in_id_i), .in_rd_i(in_rd_i), .in_we_i(in_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .hartid_o(hartid_o), .id_o(id_o), .rd_o(rd_o), .we_o(we_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One result beat presented for one cycle.
  task automatic beat(input logic [63:0] r, input logic [2:0] id);
    in_valid_i  = 1'b1;
    in_result_i = r;
    in_id_i     = id;
    in_rd_i     = 5'd7;
    in_we_i     = 1'b1;
    in_hartid_i = 64'h1;
    $display("push result=%0h id=%0d count=%0d", r, id, count_o);
    tick();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; issue_fire_i = 0; in_valid_i = 0; in_we_i = 0;
    in_result_i = '0; in_hartid_i = '0; in_id_i = '0; in_rd_i = '0; result_ready_i = 0;
    tick(); tick();
    rst_i = 0;
    chk("rst_valid", result_valid_o, 0);
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_result", result_o, 0);

    // Single beat
    issue_fire_i = 1;
    chk("single_credit0", issue_ready_o, 1);
    tick();
    issue_fire_i = 0;
    in_valid_i = 1; in_result_i = 64'h6363; in_id_i = 3; in_rd_i = 5; in_we_i = 1;
    in_hartid_i = 64'hABCD;
    chk("single_no_bypass", result_valid_o, 0);
    tick();
    in_valid_i = 0; in_result_i = 0; in_id_i = 0; in_rd_i = 0; in_we_i = 0; in_hartid_i = 0;
    chk("single_valid", result_valid_o, 1);
    chk("single_result", result_o, 64'h6363);
    chk("single_hartid", hartid_o, 64'hABCD);
    chk("single_id", id_o, 3);
    chk("single_rd", rd_o, 5);
    chk("single_we", we_o, 1);
    chk("single_count", count_o, 1);
    result_ready_i = 1;
    tick();
    result_ready_i = 0;
    $display("pop result=6363 id=3");
    chk("single_count_after", count_o, 0);
    chk("single_empty_zero", result_o, 0);

    // Fill with credit tracking: issue at k, beat k-1 returns at k.
    for (int k = 0; k <= 4; k++) begin
      issue_fire_i = (k < 4);
      in_valid_i   = (k > 0);
      in_result_i  = 64'h100 + 64'(k - 1);
      in_id_i      = 3'(k - 1);
      chk($sformatf("fill_credit_%0d", k), issue_ready_o, (k < 4));
      tick();
    end
    issue_fire_i = 0; in_valid_i = 0;
    chk("fill_count", count_o, 4);
    chk("fill_credit_full", issue_ready_o, 0);
    tick();
    chk("fill_head_stable", id_o, 0);
    result_ready_i = 1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_id_%0d", j), id_o, j);
      chk($sformatf("drain_res_%0d", j), result_o, 64'h100 + 64'(j));
      if (j == 0) chk("credit_same_cycle", issue_ready_o, 0);
      $display("pop result=%0h id=%0d", result_o, id_o);
      tick();
      if (j == 0) chk("credit_next_cycle", issue_ready_o, 1);
    end
    result_ready_i = 0;
    chk("drain_empty", count_o, 0);

    // Full with simultaneous push and pop
    for (int k = 0; k < 4; k++) beat(64'hA0 + 64'(k), 3'(k));
    chk("full_count", count_o, 4);
    result_ready_i = 1; in_valid_i = 1; in_result_i = 64'hA4; in_id_i = 4;
    tick();
    in_valid_i = 0;
    chk("pushpop_count", count_o, 4);
    chk("pushpop_overflow", overflow_o, 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pushpop_order_%0d", k), result_o, 64'hA0 + 64'(k));
      tick();
    end
    result_ready_i = 0;
    chk("pushpop_empty", count_o, 0);

    // Overflow
    for (int k = 0; k < 4; k++) beat(64'hB0 + 64'(k), 3'(k));
    beat(64'hB9, 3'd7);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_count", count_o, 4);
    result_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_contents_%0d", k), result_o, 64'hB0 + 64'(k));
      tick();
    end
    result_ready_i = 0;
    chk("ovf_drained", count_o, 0);
    flush_i = 1; tick(); flush_i = 0;
    chk("ovf_sticky_flush", overflow_o, 1);

    // Wrap-around: 10 push/pop pairs
    result_ready_i = 1;
    for (int i = 0; i <= 10; i++) begin
      in_valid_i  = (i < 10);
      in_result_i = 64'hC0 + 64'(i);
      in_id_i     = 3'(i);
      chk($sformatf("wrap_count_%0d", i), (count_o <= 1), 1);
      if (i > 0) chk($sformatf("wrap_order_%0d", i - 1), result_o, 64'hC0 + 64'(i - 1));
      tick();
    end
    in_valid_i = 0; result_ready_i = 0;
    chk("wrap_empty", count_o, 0);

    // Flush with 3 buffered, pending=1, and a beat arriving
    beat(64'hD0, 0); beat(64'hD1, 1);
    issue_fire_i = 1; beat(64'hD2, 2); issue_fire_i = 0;
    chk("flush_pre_credit", issue_ready_o, 0);
    flush_i = 1; in_valid_i = 1; in_result_i = 64'hD3;
    tick();
    flush_i = 0; in_valid_i = 0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", result_valid_o, 0);
    chk("flush_credit", issue_ready_o, 1);
    tick();
    chk("flush_push_discarded", count_o, 0);

    // Same with reset
    beat(64'hE0, 0); beat(64'hE1, 1);
    issue_fire_i = 1; beat(64'hE2, 2); issue_fire_i = 0;
    chk("rst2_pre_count", count_o, 3);
    rst_i = 1; in_valid_i = 1; in_result_i = 64'hE3;
    tick();
    rst_i = 0; in_valid_i = 0;
    chk("rst2_count", count_o, 0);
    chk("rst2_valid", result_valid_o, 0);
    chk("rst2_credit", issue_ready_o, 1);
    chk("rst2_overflow", overflow_o, 0);
    chk("rst2_result", result_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvxif_sbox_result_buffer.md
Name: cvxif_sbox_result_buffer

Overview:
Downstream stage of the CV-X-IF S-box unit. It captures the unit's registered, non-backpressurable result beat (result/hartid/id/rd/we, valid-only) into a small FIFO and drives the core's CV-X-IF result channel with a valid/ready handshake. It also returns an issue credit upstream, so the issue logic never launches an S-box instruction whose result the buffer cannot hold.

Parameters:
Depth, 4, FIFO entries; power of two, >= 2
XLEN, 64, result width
hartid_t, logic[63:0], hart id type
id_t, logic[2:0], instruction id type

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
flush_i  in  1  discard all buffered and in-flight results
issue_fire_i  in  1  S-box instruction issued this cycle; its result arrives next cycle
issue_ready_o  out  1  credit available; issue permitted this cycle
in_valid_i  in  1  result beat from S-box unit
in_result_i  in  XLEN  result data
in_hartid_i  in  hartid_t  hart id
in_id_i  in  id_t  instruction id
in_rd_i  in  5  destination register
in_we_i  in  1  register write enable
result_valid_o  out  1  head entry valid
result_ready_i  in  1  core accepts head entry
result_o  out  XLEN  head data
hartid_o  out  hartid_t  head hart id
id_o  out  id_t  head id
rd_o  out  5  head rd
we_o  out  1  head we
count_o  out  $clog2(Depth)+1  occupied entries
overflow_o  out  1  sticky error: beat arrived with no free entry

Behaviour:
- Reset (rst_i=1 at a clock edge): wptr=rptr=0, count=0, pending=0, overflow=0. All outputs read 0 except issue_ready_o, which reads 1.
- Storage: Depth entries, each holding {result, hartid, id, rd, we}. Pointers are $clog2(Depth) bits and wrap naturally, Depth-1 -> 0.
- push = in_valid_i & ~flush_i. pop = result_valid_o & result_ready_i & ~flush_i.
- First-word-fall-through: head fields are driven combinationally from mem[rptr]. result_valid_o = (count != 0).
- Head fields must be 0 when count == 0; do not expose stale data.
- Latency: push in cycle N -> result_valid_o=1 in cycle N+1. There is no same-cycle bypass.
- Head fields stay stable while result_valid_o=1 and result_ready_i=0.
- count_next = count + push - pop.
- Push when count == Depth and pop == 1: accepted; count is unchanged.
- Push when count == Depth and pop == 0: beat dropped, overflow_o set to 1. The flag is sticky until reset; flush does not clear it.
- Pop on empty cannot occur, because pop is gated by result_valid_o.
- pending register = issue_fire_i registered (1 bit, covering the S-box unit's 1-cycle latency). It clears on flush.
- issue_ready_o = (count + pending) < Depth, evaluated combinationally from registered state only.
  - A pop in the current cycle does not raise the credit until the next cycle.
  - Issue_fire_i while issue_ready_o=0 is a protocol error. It is not guarded; the overflow flag will catch the resulting drop.
- Flush: at the next edge wptr=rptr=count=pending=0. A push or pop in the flush cycle is discarded. The cycle after flush: result_valid_o=0, issue_ready_o=1.
- Reset mid-operation: all state returns to reset values at that edge regardless of in-flight beats.

Decomposition:
- Add to cvxif_sbox_instr_pkg:
  - sbox_result_t struct {result, hartid, id, rd, we}, parameterised via the module's types, or defined locally if package types cannot be parameterised.
  - constant SBOX_RESBUF_DEPTH = 4.
- No sub-module needed. Pointer/count logic is inline. A generic fifo_v3 is not used because of the credit and pending coupling.

Test Plan:
- Single beat: issue_fire_i at cycle 0. At cycle 1, in_valid_i with result=64'h0000_0000_0000_6363, id=3, rd=5, we=1. At cycle 2 expect result_valid_o=1 with the same fields; with result_ready_i=1, count_o returns to 0 at cycle 3.
- Fill/credit: result_ready_i=0; issue and return 4 beats with ids 0..3. Expect issue_ready_o=0 once count+pending reaches 4. Release ready: pops appear in order ids 0,1,2,3, and issue_ready_o returns to 1 the cycle after the first pop.
- Full with simultaneous push/pop: count=4, result_ready_i=1, and in_valid_i=1 in the same cycle -> count_o stays 4, overflow_o stays 0, and the new beat appears after the three older entries.
- Overflow: count=4, result_ready_i=0, force in_valid_i=1 -> overflow_o=1, count_o=4, and buffer contents unchanged. overflow_o remains 1 after a flush and clears only after rst_i.
- Wrap-around: run 10 push/pop pairs with incrementing ids 0..9 through the Depth=4 buffer -> output order matches exactly, and count_o never exceeds 1.
- Flush/reset: 3 entries buffered and pending=1, assert flush_i together with in_valid_i -> next cycle count_o=0, result_valid_o=0, issue_ready_o=1. Repeat with rst_i instead of flush_i -> same result, plus overflow_o=0.
